// File: rtl/av2_mv_decode_sched.sv
// Motion-vector decode scheduler: issues decoder starts per MV of a block, adds
// the decoded delta to the selected predictor with clamping, and substitutes the predictor on decoder timeout.
module av2_mv_decode_sched #(
    parameter int TIMEOUT = 255,
    parameter int MV_MAX  = 16383
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [7:0]         blk_id,
    input  logic [1:0]         blk_num_mv,
    input  logic signed [15:0] pred0_x,
    input  logic signed [15:0] pred0_y,
    input  logic signed [15:0] pred1_x,
    input  logic signed [15:0] pred1_y,
    output logic               dec_start,
    input  logic signed [15:0] dec_mv_x,
    input  logic signed [15:0] dec_mv_y,
    input  logic               dec_mv_valid,
    output logic               dec_mv_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_mv_x,
    output logic signed [15:0] out_mv_y,
    output logic [7:0]         out_blk_id,
    output logic               out_ref_idx,
    output logic               out_last,
    output logic               out_err,
    output logic               busy,
    output logic [7:0]         err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [16:0] LP_HI = 17'(MV_MAX);
    localparam logic signed [16:0] LP_LO = 17'(-MV_MAX - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_MV, OUT} state_t;

    state_t             r_state, w_next;
    logic [TW-1:0]      r_tcnt;
    logic               r_idx, r_last_idx, r_err;
    logic [7:0]         r_blk_id, r_err_cnt;
    logic signed [15:0] r_p0x, r_p0y, r_p1x, r_p1y, r_out_x, r_out_y;
    logic signed [15:0] w_sel_x, w_sel_y;
    logic signed [16:0] w_sum_x, w_sum_y;
    logic               w_tmo;

    function automatic logic signed [15:0] f_clamp(input logic signed [16:0] s);
        if (s > LP_HI) return LP_HI[15:0];
        if (s < LP_LO) return LP_LO[15:0];
        return s[15:0];
    endfunction

    assign w_sel_x = r_idx ? r_p1x : r_p0x;
    assign w_sel_y = r_idx ? r_p1y : r_p0y;
    assign w_sum_x = {w_sel_x[15], w_sel_x} + {dec_mv_x[15], dec_mv_x};
    assign w_sum_y = {w_sel_y[15], w_sel_y} + {dec_mv_y[15], dec_mv_y};
    // Fires on the TIMEOUT-th silent WAIT_MV cycle; a delta on that same cycle still wins.
    assign w_tmo   = (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        blk_ready    = 1'b0;
        dec_start    = 1'b0;
        dec_mv_ready = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) w_next = START;
            end
            START: begin
                dec_start = 1'b1;
                w_next    = WAIT_MV;
            end
            WAIT_MV: begin
                dec_mv_ready = 1'b1;
                if (dec_mv_valid || w_tmo) w_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = (r_idx == r_last_idx) ? IDLE : START;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt     <= '0;
            r_idx      <= 1'b0;
            r_last_idx <= 1'b0;
            r_err      <= 1'b0;
            r_blk_id   <= '0;
            r_err_cnt  <= '0;
            r_p0x      <= '0;
            r_p0y      <= '0;
            r_p1x      <= '0;
            r_p1y      <= '0;
            r_out_x    <= '0;
            r_out_y    <= '0;
        end else begin
            case (r_state)
                IDLE: if (blk_valid) begin
                    r_blk_id   <= blk_id;
                    r_p0x      <= pred0_x;
                    r_p0y      <= pred0_y;
                    r_p1x      <= pred1_x;
                    r_p1y      <= pred1_y;
                    r_idx      <= 1'b0;
                    r_last_idx <= (blk_num_mv == 2'd2);
                end
                START: r_tcnt <= '0;
                WAIT_MV: begin
                    if (dec_mv_valid) begin
                        r_out_x <= f_clamp(w_sum_x);
                        r_out_y <= f_clamp(w_sum_y);
                        r_err   <= 1'b0;
                    end else if (w_tmo) begin
                        r_out_x <= w_sel_x;
                        r_out_y <= w_sel_y;
                        r_err   <= 1'b1;
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                OUT: if (out_ready && (r_idx != r_last_idx)) r_idx <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign out_last    = out_valid && (r_idx == r_last_idx);
    assign out_mv_x    = r_out_x;
    assign out_mv_y    = r_out_y;
    assign out_blk_id  = r_blk_id;
    assign out_ref_idx = r_idx;
    assign out_err     = r_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_av2_mv_decode_sched.sv
// Randomized bench for av2_mv_decode_sched against a cycle-scheduled behavioural model.
module tb_av2_mv_decode_sched;

    localparam int TMO = 255;
    localparam int MVM = 16383;

    logic               clk = 1'b0;
    logic               rst;
    logic               blk_valid, blk_ready;
    logic [7:0]         blk_id;
    logic [1:0]         blk_num_mv;
    logic signed [15:0] pred0_x, pred0_y, pred1_x, pred1_y;
    logic               dec_start;
    logic signed [15:0] dec_mv_x, dec_mv_y;
    logic               dec_mv_valid, dec_mv_ready;
    logic               out_valid, out_ready;
    logic signed [15:0] out_mv_x, out_mv_y;
    logic [7:0]         out_blk_id;
    logic               out_ref_idx, out_last, out_err, busy;
    logic [7:0]         err_cnt;

    always #5 clk = ~clk;

    av2_mv_decode_sched #(.TIMEOUT(TMO), .MV_MAX(MVM)) dut (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_id(blk_id), .blk_num_mv(blk_num_mv),
        .pred0_x(pred0_x), .pred0_y(pred0_y), .pred1_x(pred1_x), .pred1_y(pred1_y),
        .dec_start(dec_start), .dec_mv_x(dec_mv_x), .dec_mv_y(dec_mv_y),
        .dec_mv_valid(dec_mv_valid), .dec_mv_ready(dec_mv_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_mv_x(out_mv_x), .out_mv_y(out_mv_y),
        .out_blk_id(out_blk_id), .out_ref_idx(out_ref_idx), .out_last(out_last),
        .out_err(out_err), .busy(busy), .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_errcnt = 0;
    int n_start  = 0;
    int t_px[2], t_py[2], t_dx[2], t_dy[2], t_dly[2], t_bp[2];

    always @(posedge clk) if (dec_start) n_start++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_mv(input int p, input int d);
        int s;
        s = p + d;
        if (s > MVM) s = MVM;
        if (s < -MVM - 1) s = -MVM - 1;
        return s;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic junk_dec();
        dec_mv_valid = 1'($urandom_range(0, 1));
        dec_mv_x     = 16'($urandom);
        dec_mv_y     = 16'($urandom);
    endtask

    // Drives one block through the DUT, checking every cycle against the model.
    task automatic run_block(input logic [7:0] id, input logic [1:0] num);
        int cnt;
        cnt = (num == 2'd2) ? 2 : 1;
        chk("idle_ready", 32'(blk_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        blk_valid  = 1'b1;
        blk_id     = id;
        blk_num_mv = num;
        pred0_x = 16'(t_px[0]); pred0_y = 16'(t_py[0]);
        pred1_x = 16'(t_px[1]); pred1_y = 16'(t_py[1]);
        @(negedge clk);
        blk_valid = 1'b0;
        pred0_x = 16'($urandom); pred0_y = 16'($urandom);
        pred1_x = 16'($urandom); pred1_y = 16'($urandom);
        blk_id  = 8'($urandom);
        for (int i = 0; i < cnt; i++) begin
            int ex, ey;
            bit tmo;
            chk("start_pulse", 32'(dec_start), 1);
            chk("start_nout", 32'(out_valid), 0);
            chk("start_busy", 32'(busy), 1);
            chk("start_nrdy", 32'(dec_mv_ready), 0);
            junk_dec();
            @(negedge clk);
            dec_mv_valid = 1'b0;
            for (int w = 0; w < TMO; w++) begin
                chk("wait_rdy", 32'(dec_mv_ready), 1);
                chk("wait_nstart", 32'(dec_start), 0);
                if (w == t_dly[i]) begin
                    dec_mv_valid = 1'b1;
                    dec_mv_x = 16'(t_dx[i]);
                    dec_mv_y = 16'(t_dy[i]);
                end
                @(negedge clk);
                dec_mv_valid = 1'b0;
                if (w == t_dly[i]) break;
            end
            tmo = (t_dly[i] >= TMO);
            ex  = tmo ? t_px[i] : ref_mv(t_px[i], t_dx[i]);
            ey  = tmo ? t_py[i] : ref_mv(t_py[i], t_dy[i]);
            if (tmo && m_errcnt < 255) m_errcnt++;
            for (int b = 0; b <= t_bp[i]; b++) begin
                out_ready = (b == t_bp[i]);
                junk_dec();
                chk("out_valid", 32'(out_valid), 1);
                chk("out_x", 32'(out_mv_x), ex);
                chk("out_y", 32'(out_mv_y), ey);
                chk("out_id", 32'(out_blk_id), 32'(id));
                chk("out_ref", 32'(out_ref_idx), i);
                chk("out_last", 32'(out_last), (i == cnt - 1) ? 1 : 0);
                chk("out_err", 32'(out_err), tmo ? 1 : 0);
                chk("err_cnt", 32'(err_cnt), m_errcnt);
                chk("out_nstart", 32'(dec_start), 0);
                chk("out_nrdy", 32'(dec_mv_ready), 0);
                @(negedge clk);
            end
            out_ready    = 1'b0;
            dec_mv_valid = 1'b0;
        end
    endtask

    task automatic set_mv(input int i, input int px, input int py, input int dx, input int dy,
                          input int dly, input int bp);
        t_px[i] = px; t_py[i] = py; t_dx[i] = dx; t_dy[i] = dy; t_dly[i] = dly; t_bp[i] = bp;
    endtask

    initial begin
        int s0;
        rst = 1'b1; blk_valid = 1'b0; blk_id = '0; blk_num_mv = '0;
        pred0_x = '0; pred0_y = '0; pred1_x = '0; pred1_y = '0;
        dec_mv_x = '0; dec_mv_y = '0; dec_mv_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(dec_start), 0);
        chk("rst_drdy", 32'(dec_mv_ready), 0);
        chk("rst_oval", 32'(out_valid), 0);
        chk("rst_oerr", 32'(out_err), 0);
        chk("rst_olast", 32'(out_last), 0);
        chk("rst_ox", 32'(out_mv_x), 0);
        chk("rst_oy", 32'(out_mv_y), 0);
        chk("rst_oid", 32'(out_blk_id), 0);
        chk("rst_oref", 32'(out_ref_idx), 0);
        chk("rst_ecnt", 32'(err_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bready", 32'(blk_ready), 1);

        // zero MV
        set_mv(0, 0, 0, 0, 0, 0, 0);
        run_block(8'h11, 2'd1);
        // compound two-MV block
        s0 = n_start;
        set_mv(0, 4, 2, 1, -1, 0, 0);
        set_mv(1, -4, -2, -6, 10, 0, 0);
        run_block(8'h22, 2'd2);
        chk("two_starts", 32'(n_start - s0), 2);
        // clamp both directions
        set_mv(0, 16000, -16000, 1000, -1000, 0, 0);
        run_block(8'h33, 2'd1);
        // silent decoder, then a late delta in IDLE must be ignored
        set_mv(0, 123, -77, 5, 5, TMO, 0);
        run_block(8'h44, 2'd1);
        dec_mv_valid = 1'b1;
        @(negedge clk);
        dec_mv_valid = 1'b0;
        chk("late_busy", 32'(busy), 0);
        chk("late_ecnt", 32'(err_cnt), 1);
        // delta on the timeout cycle itself wins
        set_mv(0, 10, 20, 1, 2, TMO - 1, 0);
        run_block(8'h55, 2'd1);
        // backpressure on first MV of a two-MV block
        set_mv(0, 100, 200, 3, 4, 1, 10);
        set_mv(1, -100, -200, -3, -4, 2, 0);
        run_block(8'h66, 2'd2);

        // reset while waiting on the decoder
        blk_valid = 1'b1; blk_num_mv = 2'd2; blk_id = 8'h77;
        @(negedge clk);
        blk_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rw_state", 32'(dec_mv_ready), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_errcnt = 0;
        chk("rw_busy", 32'(busy), 0);
        chk("rw_oval", 32'(out_valid), 0);
        chk("rw_bready", 32'(blk_ready), 1);
        chk("rw_ecnt", 32'(err_cnt), 0);
        dec_mv_valid = 1'b1; dec_mv_x = 16'sd9; dec_mv_y = 16'sd9;
        @(negedge clk);
        dec_mv_valid = 1'b0;
        chk("rw_ign_busy", 32'(busy), 0);
        chk("rw_ign_oval", 32'(out_valid), 0);
        set_mv(0, -5, 7, 2, -3, 0, 1);
        run_block(8'h78, 2'd1);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                int dly;
                dly = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? TMO : TMO - 1)
                                                  : int'($urandom_range(0, 3));
                set_mv(i, rnd16(), rnd16(), rnd16(), rnd16(), dly, int'($urandom_range(0, 3)));
            end
            run_block(8'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
